// File: rtl/upsample2x_if.sv
// Pixel stream bundle for the 2x2 upsampler: input handshake, layer mode and output handshake.
// The bench drives the master side and the upsampler sits on the slave side.
interface upsample2x_if #(
    parameter int DW = 32
);
    logic                 state;
    logic                 ivalid;
    logic                 iready;
    logic signed [DW-1:0] din;
    logic                 ovalid;
    logic                 oready;
    logic signed [DW-1:0] dout;
    logic                 olast;

    modport master (
        output state, ivalid, din, oready,
        input  iready, ovalid, dout, olast
    );

    modport slave (
        input  state, ivalid, din, oready,
        output iready, ovalid, dout, olast
    );
endinterface

// File: rtl/upsample2x.sv
// Nearest-neighbour 2x2 upsampler. Each pooled row is emitted with every pixel doubled,
// then replayed once from the line buffer to double it vertically.
module upsample2x #(
    parameter int DW = 32,
    parameter int W0 = 12,
    parameter int W1 = 4
) (
    input  logic         clk,
    input  logic         rstn,
    upsample2x_if.slave  bus
);
    localparam int LBW = (W0 > W1) ? W0 : W1;

    typedef enum logic {LOAD, REPLAY} fsm_t;

    fsm_t                 fsm;
    logic [3:0]           icol;
    logic [3:0]           rcol;
    logic [3:0]           w;
    logic                 hold_vld;
    logic                 hold_last;
    logic                 dup;
    logic                 ovalid_q;
    logic                 olast_q;
    logic signed [DW-1:0] dout_q;
    logic signed [DW-1:0] linebuf [LBW];

    logic [3:0] w_sel;
    logic [3:0] w_cur;
    logic       is_last;
    logic       iready_c;
    logic       i_fire;
    logic       o_fire;

    // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch is inferred.
    always_comb begin
        w_sel    = bus.state ? 4'(W1) : 4'(W0);
        w_cur    = (icol == 4'd0) ? w_sel : w;
        is_last  = (icol == w_cur - 4'd1);
        // Once the last column is held, input stalls until the replay has finished.
        iready_c = (fsm == LOAD) && !hold_last && (!hold_vld || (dup && bus.oready));
        i_fire   = iready_c && bus.ivalid;
        o_fire   = ovalid_q && bus.oready;
    end

    assign bus.iready = iready_c;
    assign bus.ovalid = ovalid_q;
    assign bus.dout   = dout_q;
    assign bus.olast  = olast_q;

    // NOTE: the line buffer is pure storage and has no reset; stale words are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (i_fire) begin
            linebuf[icol] <= bus.din;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fsm       <= LOAD;
            icol      <= '0;
            rcol      <= '0;
            w         <= '0;
            hold_vld  <= 1'b0;
            hold_last <= 1'b0;
            dup       <= 1'b0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            dout_q    <= '0;
        end else begin
            case (fsm)
                LOAD: begin
                    if (o_fire) begin
                        if (!dup) begin
                            dup     <= 1'b1;
                            olast_q <= hold_last;
                        end else begin
                            dup      <= 1'b0;
                            olast_q  <= 1'b0;
                            hold_vld <= 1'b0;
                            if (hold_last) begin
                                hold_last <= 1'b0;
                                fsm       <= REPLAY;
                                rcol      <= '0;
                                dout_q    <= linebuf[0];
                            end else begin
                                ovalid_q <= 1'b0;
                            end
                        end
                    end
                    // A new pixel may land on the same edge the hold register releases.
                    if (i_fire) begin
                        hold_vld  <= 1'b1;
                        hold_last <= is_last;
                        dout_q    <= bus.din;
                        ovalid_q  <= 1'b1;
                        dup       <= 1'b0;
                        olast_q   <= 1'b0;
                        icol      <= is_last ? 4'd0 : icol + 4'd1;
                        if (icol == 4'd0) begin
                            w <= w_sel;
                        end
                    end
                end
                REPLAY: begin
                    if (o_fire) begin
                        if (!dup) begin
                            dup     <= 1'b1;
                            olast_q <= (rcol == w - 4'd1);
                        end else begin
                            dup     <= 1'b0;
                            olast_q <= 1'b0;
                            if (rcol == w - 4'd1) begin
                                fsm      <= LOAD;
                                ovalid_q <= 1'b0;
                                rcol     <= '0;
                            end else begin
                                rcol   <= rcol + 4'd1;
                                dout_q <= linebuf[rcol + 4'd1];
                            end
                        end
                    end
                end
                default: fsm <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_upsample2x.sv
// Scoreboard bench for upsample2x: the driver queues the full 2x2 pattern of each row,
// and a monitor pops and compares every output transfer and checks stability under backpressure.
module tb_upsample2x;
    localparam int DW = 32;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 last;
        logic                 replay;
    } exp_t;

    logic clk;
    logic rstn;
    logic rand_rdy;
    int   checks;
    int   errors;
    exp_t q[$];
    logic signed [DW-1:0] px [12];

    upsample2x_if #(.DW(DW)) bus ();

    upsample2x #(.DW(DW), .W0(12), .W1(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Downstream ready: always 1, or a coin flip each cycle when rand_rdy is set.
    initial begin
        bus.oready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.oready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a transfer is decided at the negedge before the edge that performs it.
    initial begin
        logic                 held;
        logic signed [DW-1:0] hd;
        logic                 hl;
        exp_t                 e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                check("stall_ovalid", bus.ovalid, 1);
                check("stall_dout", bus.dout, hd);
                check("stall_olast", bus.olast, hl);
            end
            held = 1'b0;
            if (bus.ovalid && !bus.oready) begin
                held = 1'b1;
                hd   = bus.dout;
                hl   = bus.olast;
            end else if (bus.ovalid && bus.oready) begin
                if (q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("beat_dout", bus.dout, e.data);
                    check("beat_olast", bus.olast, e.last);
                    if (e.replay) begin
                        check("replay_iready", bus.iready, 0);
                    end
                end
            end
        end
    end

    task automatic send(input logic signed [DW-1:0] v, input logic st);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        bus.ivalid = 1'b1;
        bus.din    = v;
        bus.state  = st;
        while (!ok && n < 400) begin
            @(negedge clk);
            ok = bus.iready;
            n++;
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1;
        bus.ivalid = 1'b0;
        if (ok) begin
            check("first_copy_valid", bus.ovalid, 1);
            check("first_copy_dout", bus.dout, v);
        end
    endtask

    task automatic run_row(input int w, input int sw_at, input logic st0, input logic st1, input int gap_max);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < w; c++) begin
                for (int d = 0; d < 2; d++) begin
                    exp_t e;
                    e.data   = px[c];
                    e.last   = (d == 1) && (c == w - 1);
                    e.replay = (r == 1);
                    q.push_back(e);
                end
            end
        end
        for (int c = 0; c < w; c++) begin
            int g;
            send(px[c], (c < sw_at) ? st0 : st1);
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
        check("idle_after_row", bus.ovalid, 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rand_rdy   = 1'b0;
        rstn       = 1'b0;
        bus.ivalid = 1'b0;
        bus.din    = '0;
        bus.state  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ovalid", bus.ovalid, 0);
        check("reset_dout", bus.dout, 0);
        check("reset_olast", bus.olast, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("reset_iready", bus.iready, 1);

        // Width 12, back-to-back, no backpressure.
        for (int i = 0; i < 12; i++) px[i] = DW'(i + 1);
        run_row(12, 12, 1'b0, 1'b0, 0);
        drain();

        // Width 4 with signed pixels.
        px[0] = -3; px[1] = 7; px[2] = 0; px[3] = -1;
        run_row(4, 4, 1'b1, 1'b1, 0);
        drain();

        // Random backpressure over two width-12 rows.
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) px[i] = DW'(i + 1);
        run_row(12, 12, 1'b0, 1'b0, 0);
        for (int i = 0; i < 12; i++) px[i] = DW'(-1000 * i + 17);
        run_row(12, 12, 1'b0, 1'b0, 0);
        drain();
        rand_rdy = 1'b0;

        // Input gaps of 0-3 cycles in width-4 mode.
        px[0] = 32'sh7fffffff; px[1] = -32'sh80000000; px[2] = 5; px[3] = -6;
        run_row(4, 4, 1'b1, 1'b1, 3);
        px[0] = 11; px[1] = -22; px[2] = 33; px[3] = -44;
        run_row(4, 4, 1'b1, 1'b1, 3);
        drain();

        // Mode changes after five pixels: row stays at width 12, next row is width 4.
        for (int i = 0; i < 12; i++) px[i] = DW'(50 + i);
        run_row(12, 5, 1'b0, 1'b1, 0);
        px[0] = 70; px[1] = 71; px[2] = 72; px[3] = 73;
        run_row(4, 4, 1'b1, 1'b1, 0);
        drain();

        // Reset during replay, then a fresh row must carry no stale pixels.
        for (int i = 0; i < 12; i++) px[i] = DW'(200 + i);
        run_row(12, 12, 1'b0, 1'b0, 0);
        begin
            int n;
            n = 0;
            while (q.size() > 20 && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("reached_replay", (q.size() <= 20) ? 1 : 0, 1);
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("midreset_ovalid", bus.ovalid, 0);
        check("midreset_iready", bus.iready, 1);
        check("midreset_olast", bus.olast, 0);
        for (int i = 0; i < 12; i++) px[i] = DW'(100 + i);
        run_row(12, 12, 1'b0, 1'b0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
